// File: rtl/request_queue_if.sv
// rtl/request_queue_if.sv - parser/scheduler handshake bundle for request_queue
// peak_count exists only when QUEUE_PEAK_EN is defined.
interface request_queue_if #(
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = 32,
   parameter int AGE_WIDTH     = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                     in_valid;
   logic [1:0]               in_op;
   logic [ADDRESS_WIDTH-1:0] in_addr;
   logic                     in_ready;
   logic                     out_valid;
   logic [1:0]               out_op;
   logic [ADDRESS_WIDTH-1:0] out_addr;
   logic [AGE_WIDTH-1:0]     out_age;
   logic                     out_ready;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     empty;

`ifdef QUEUE_PEAK_EN
   logic [CNT_W-1:0]         peak_count;

   modport slave (
      input  in_valid, in_op, in_addr, out_ready,
      output in_ready, out_valid, out_op, out_addr, out_age,
             count, full, empty, peak_count
   );
   modport master (
      output in_valid, in_op, in_addr, out_ready,
      input  in_ready, out_valid, out_op, out_addr, out_age,
             count, full, empty, peak_count
   );
`else
   modport slave (
      input  in_valid, in_op, in_addr, out_ready,
      output in_ready, out_valid, out_op, out_addr, out_age,
             count, full, empty
   );
   modport master (
      output in_valid, in_op, in_addr, out_ready,
      input  in_ready, out_valid, out_op, out_addr, out_age,
             count, full, empty
   );
`endif
endinterface

// File: rtl/request_queue.sv
// rtl/request_queue.sv - in-order request buffer with per-entry wait-age tracking
// Optional QUEUE_PEAK_EN adds a high-water-mark register on peak_count.
module request_queue #(
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = 32,
   parameter int AGE_WIDTH     = 8
) (
   input  logic           clk,
   input  logic           rst,
   request_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0]       OP_NOP   = 2'd3;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ACTIVE,
      ST_FULL
   } occ_state_t;

   occ_state_t               state_q, state_d;
   logic [PTR_W-1:0]         head_q, head_d;
   logic [PTR_W-1:0]         tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [1:0]               op_q   [DEPTH];
   logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
   logic [AGE_WIDTH-1:0]     age_q  [DEPTH];
   logic [AGE_WIDTH-1:0]     age_d  [DEPTH];
   logic [PTR_W-1:0]         slot;
   logic                     occupied;
   logic                     in_ready;
   logic                     out_valid;
   logic                     enq;
   logic                     deq;

   // in_ready comes from registered state only, so a dequeue never frees a slot in the same cycle.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign enq       = bus.in_valid && in_ready && (bus.in_op != OP_NOP);
   assign deq       = out_valid && bus.out_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) head_d = head_q + 1'b1;
      if (enq) tail_d = tail_q + 1'b1;
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (count_d == '0)
         state_d = ST_EMPTY;
      else if (count_d == CNT_FULL)
         state_d = ST_FULL;
      else
         state_d = ST_ACTIVE;
   end

   always_comb begin
      slot     = '0;
      occupied = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot     = PTR_W'(i);
         occupied = ({1'b0, slot - head_q} < count_q);
         if (enq && (slot == tail_q))
            age_d[i] = '0;
         else if (occupied && !(deq && (slot == head_q)))
            age_d[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + 1'b1;
         else
            age_d[i] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         age_q   <= age_d;
      end
   end

   // Payload storage needs no reset; outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (enq) begin
         op_q[tail_q]   <= bus.in_op;
         addr_q[tail_q] <= bus.in_addr;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_op    = out_valid ? op_q[head_q]   : OP_NOP;
   assign bus.out_addr  = out_valid ? addr_q[head_q] : '0;
   assign bus.out_age   = out_valid ? age_q[head_q]  : '0;
   assign bus.count     = count_q;
   assign bus.full      = (state_q == ST_FULL);
   assign bus.empty     = (state_q == ST_EMPTY);

`ifdef QUEUE_PEAK_EN
   logic [CNT_W-1:0] peak_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         peak_q <= '0;
      else if (count_q > peak_q)
         peak_q <= count_q;
   end

   assign bus.peak_count = peak_q;
`endif
endmodule

// File: doc/request_queue.md
# request_queue

Parametrised buffering stage between the trace parser and the memory-controller scheduler. It accepts parsed operations (opcode plus address) over a valid/ready handshake, discards NOP, and stores up to DEPTH requests in arrival order. It presents the oldest request to the scheduler together with the number of cycles that request has waited. Opcode encoding is `parsed_op_t` from `global_defs`: DATA_READ=0, DATA_WRITE=1, OPCODE_FETCH=2, NOP=3.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, minimum 2.
- ADDRESS_WIDTH, `global_defs::ADDRESS_WIDTH` (32): request address width.
- AGE_WIDTH, 8: width of each per-entry wait-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  parser presents a request.
- in_op  in  2  `parsed_op_t` opcode.
- in_addr  in  ADDRESS_WIDTH  request address.
- in_ready  out  1  queue can accept a request this cycle.
- out_valid  out  1  head entry holds a valid request.
- out_op  out  2  head opcode; NOP when empty.
- out_addr  out  ADDRESS_WIDTH  head address; 0 when empty.
- out_age  out  AGE_WIDTH  cycles the head request has waited; 0 when empty.
- out_ready  in  1  scheduler consumes the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- peak_count  out  $clog2(DEPTH)+1  present only with QUEUE_PEAK_EN.

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; occupancy is held in a separate count register.
- Enqueue fires when in_valid && in_ready && in_op != NOP. The request is written at tail, tail increments, and the entry's age is cleared to 0.
- NOP with in_valid high is accepted (in_ready is honoured) and discarded: no write, no pointer or count change.
- in_ready = !full. It is computed from registered state only, with no combinational dependence on out_ready.
- Dequeue fires when out_valid && out_ready: head increments and count decrements. out_ready while empty is ignored.
- Simultaneous enqueue and dequeue: both happen and count is unchanged. When full, a dequeue does not open a slot in the same cycle (in_ready is already 0).
- Age: every occupied entry increments its age each cycle and saturates at 2^AGE_WIDTH-1. Free entries hold 0.
- Occupancy states, derived from count:
  - EMPTY (count 0) -> ACTIVE on enqueue.
  - ACTIVE -> FULL when count reaches DEPTH.
  - ACTIVE -> EMPTY when the last entry is dequeued.
  - FULL -> ACTIVE on dequeue.
- out_* are driven combinationally from the registered head entry. While empty, outputs are forced to NOP / 0 / 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - head=0, tail=0, count=0, all ages 0.
  - empty=1, full=0, in_ready=1, out_valid=0, out_op=NOP, out_addr=0, out_age=0, peak_count=0.
  - A reset mid-operation flushes all entries; any request in flight on that edge is lost.
- Enqueue-to-out_valid latency is 1 cycle; there is no bypass path from in_* to out_*.
- out_age of a newly enqueued head reads 0 in its first visible cycle and +1 each following cycle.
- Dequeue takes effect at the edge; the next entry appears on out_* in the following cycle.
- The handshake is combinational on both sides: transfer happens at the edge where valid and ready are both high.

## Configuration
- QUEUE_PEAK_EN defined:
  - peak_count port exists and records the maximum count reached since reset.
  - It updates one cycle after the count change and is cleared only by rst.
- QUEUE_PEAK_EN undefined: port and register are absent; all other behaviour is identical.

## Test plan
- Reset then idle 5 cycles -> empty=1, in_ready=1, out_valid=0, out_op=NOP, out_addr=0, count=0.
- Enqueue READ 0x0000_1000, WRITE 0x0000_2000, FETCH 0x0000_3000 back-to-back, out_ready=0 -> count=3; out_op=DATA_READ, out_addr=0x1000 one cycle after the first enqueue; then drain with out_ready=1 -> order 0x1000, 0x2000, 0x3000, then empty=1.
- NOP with in_valid=1 for 4 cycles -> count stays 0, in_ready=1, out_valid=0.
- Fill 16 entries (DEPTH=16) -> full=1, in_ready=0; a 17th request is held. One dequeue -> full=0 the next cycle; the held request is accepted and wrap-around order is preserved.
- Simultaneous enqueue and dequeue at count=5 for 10 cycles -> count remains 5 and FIFO order holds; with AGE_WIDTH=4 the head waits 20 cycles -> out_age saturates at 15.
- Assert rst at count=7 between edges -> immediate empty=1, out_valid=0; with QUEUE_PEAK_EN, peak_count reads 7 before reset and 0 after.
